// File: rtl/scope_buffer_scheduler_if.sv
// Handshake and status bundle between the capture/DMA side and the scope buffer scheduler.
// The master side drives frame, DMA and release events; the slave side is the scheduler itself.
interface scope_buffer_scheduler_if #(
    parameter int N_BUFFERS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(N_BUFFERS)
);
    logic                  enable;
    logic [ADDR_WIDTH-1:0] buffer_base;
    logic [ADDR_WIDTH-1:0] buffer_stride;
    logic                  frame_done;
    logic                  dma_done;
    logic                  release_valid;
    logic [IDX_WIDTH-1:0]  release_index;
    logic                  start_dma;
    logic [ADDR_WIDTH-1:0] dma_address;
    logic                  buffer_ready;
    logic [IDX_WIDTH-1:0]  ready_index;
    logic [N_BUFFERS-1:0]  full_mask;
    logic                  capture_inhibit;
    logic                  busy;
    logic [15:0]           overrun_count;

    modport master (
        output enable, buffer_base, buffer_stride, frame_done, dma_done,
               release_valid, release_index,
        input  start_dma, dma_address, buffer_ready, ready_index, full_mask,
               capture_inhibit, busy, overrun_count
    );

    modport slave (
        input  enable, buffer_base, buffer_stride, frame_done, dma_done,
               release_valid, release_index,
        output start_dma, dma_address, buffer_ready, ready_index, full_mask,
               capture_inhibit, busy, overrun_count
    );
endinterface

// File: rtl/scope_buffer_scheduler.sv
// Round-robin scheduler that assigns capture frames to a ring of host buffers,
// issues one DMA start per accepted frame and counts frames it has to drop.
module scope_buffer_scheduler #(
    parameter int N_BUFFERS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(N_BUFFERS)
) (
    input logic                    clock,
    input logic                    reset,
    scope_buffer_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ARMED     = 2'd1;
    localparam logic [1:0] IN_FLIGHT = 2'd2;
    localparam logic [1:0] DRAIN     = 2'd3;

    logic [1:0]            state;
    logic [IDX_WIDTH-1:0]  next_idx;
    logic [IDX_WIDTH-1:0]  flight_idx;
    logic [IDX_WIDTH-1:0]  sel_idx;
    logic                  sel_found;
    logic [N_BUFFERS-1:0]  full_mask;
    logic [N_BUFFERS-1:0]  flight_mask;
    logic [N_BUFFERS-1:0]  occupied;
    logic [N_BUFFERS-1:0]  release_mask;
    logic [N_BUFFERS-1:0]  done_mask;
    logic                  start_dma;
    logic                  buffer_ready;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] dma_address;
    logic [IDX_WIDTH-1:0]  ready_index;
    logic [15:0]           overrun_count;
    logic                  transferring;
    logic                  completing;
    logic                  drop_frame;

    assign transferring = (state == IN_FLIGHT) || (state == DRAIN);
    assign completing   = transferring && bus.dma_done;

    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        flight_mask = '0;
        done_mask   = '0;
        if (busy) flight_mask[flight_idx] = 1'b1;
        if (completing) done_mask[flight_idx] = 1'b1;
    end

    assign occupied = full_mask | flight_mask;

    // Eligibility uses the registered mask, so a same-cycle release never helps.
    always_comb begin : next_free_scan
        int                   cand;
        logic [IDX_WIDTH-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        sel_found = 1'b0;
        sel_idx   = next_idx;
        for (int k = 0; k < N_BUFFERS; k++) begin
            cand = int'(next_idx) + k;
            if (cand >= N_BUFFERS) cand = cand - N_BUFFERS;
            cand_idx = IDX_WIDTH'(cand);
            if (!sel_found && !occupied[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // A buffer completing this cycle has no full bit yet, so releasing it is a no-op.
    always_comb begin
        release_mask = '0;
        if (bus.release_valid && (int'(bus.release_index) < N_BUFFERS)
            && full_mask[bus.release_index]) begin
            release_mask[bus.release_index] = 1'b1;
        end
    end

    assign drop_frame = bus.frame_done &&
                        (transferring || ((state == ARMED) && bus.enable && !sel_found));

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            next_idx      <= '0;
            flight_idx    <= '0;
            full_mask     <= '0;
            start_dma     <= 1'b0;
            buffer_ready  <= 1'b0;
            busy          <= 1'b0;
            dma_address   <= '0;
            ready_index   <= '0;
            overrun_count <= '0;
        end else begin
            start_dma    <= 1'b0;
            buffer_ready <= 1'b0;
            full_mask    <= (full_mask & ~release_mask) | done_mask;
            if (drop_frame && (overrun_count != 16'hFFFF)) begin
                overrun_count <= overrun_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.enable) state <= ARMED;
                end
                ARMED: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else if (bus.frame_done && sel_found) begin
                        start_dma   <= 1'b1;
                        busy        <= 1'b1;
                        flight_idx  <= sel_idx;
                        dma_address <= bus.buffer_base + ADDR_WIDTH'(sel_idx) * bus.buffer_stride;
                        state       <= IN_FLIGHT;
                    end
                end
                IN_FLIGHT, DRAIN: begin
                    if (bus.dma_done) begin
                        buffer_ready <= 1'b1;
                        ready_index  <= flight_idx;
                        busy         <= 1'b0;
                        next_idx     <= (int'(flight_idx) == N_BUFFERS - 1) ? '0
                                                                           : flight_idx + IDX_WIDTH'(1);
                        state        <= ((state == IN_FLIGHT) && bus.enable) ? ARMED : IDLE;
                    end else if (!bus.enable) begin
                        state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_dma       = start_dma;
    assign bus.dma_address     = dma_address;
    assign bus.buffer_ready    = buffer_ready;
    assign bus.ready_index     = ready_index;
    assign bus.full_mask       = full_mask;
    assign bus.capture_inhibit = &occupied;
    assign bus.busy            = busy;
    assign bus.overrun_count   = overrun_count;
endmodule

// File: tb/tb_scope_buffer_scheduler.sv
// Directed bench for scope_buffer_scheduler: expected DMA addresses and ready indices are
// queued when a frame or completion is driven and compared when the scheduler reports it.
module tb_scope_buffer_scheduler;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0000_1000;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] addr_q[$];
    int          idx_q[$];

    scope_buffer_scheduler_if #(.N_BUFFERS(4), .ADDR_WIDTH(32)) bus ();

    scope_buffer_scheduler #(.N_BUFFERS(4), .ADDR_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input logic [31:0] base, input logic [31:0] stride);
        reset             = 1'b0;
        bus.enable        = 1'b0;
        bus.frame_done    = 1'b0;
        bus.dma_done      = 1'b0;
        bus.release_valid = 1'b0;
        bus.release_index = '0;
        bus.buffer_base   = base;
        bus.buffer_stride = stride;
        tick();
        tick();
        reset      = 1'b1;
        bus.enable = 1'b1;
        tick();
    endtask

    task automatic frame_start(input logic [31:0] exp_addr);
        addr_q.push_back(exp_addr);
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        check("start_dma", bus.start_dma, 1);
        check("busy_on", bus.busy, 1);
        if (bus.start_dma) check("dma_address", bus.dma_address, addr_q.pop_front());
        tick();
        check("start_pulse_end", bus.start_dma, 0);
    endtask

    task automatic frame_drop(input logic [15:0] exp_overrun);
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        check("drop_no_start", bus.start_dma, 0);
        check("overrun_count", bus.overrun_count, exp_overrun);
    endtask

    task automatic transfer_done(input int idx);
        idx_q.push_back(idx);
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        check("buffer_ready", bus.buffer_ready, 1);
        if (bus.buffer_ready) check("ready_index", bus.ready_index, idx_q.pop_front());
        check("busy_off", bus.busy, 0);
        tick();
        check("ready_pulse_end", bus.buffer_ready, 0);
    endtask

    task automatic release_buf(input int idx);
        bus.release_valid = 1'b1;
        bus.release_index = 2'(idx);
        tick();
        bus.release_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b0;
        bus.enable        = 1'b0;
        bus.frame_done    = 1'b0;
        bus.dma_done      = 1'b0;
        bus.release_valid = 1'b0;
        bus.release_index = '0;
        bus.buffer_base   = BASE;
        bus.buffer_stride = STRIDE;
        tick();
        check("rst_start_dma", bus.start_dma, 0);
        check("rst_dma_address", bus.dma_address, 0);
        check("rst_buffer_ready", bus.buffer_ready, 0);
        check("rst_full_mask", bus.full_mask, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun_count, 0);
        check("rst_inhibit", bus.capture_inhibit, 0);

        // Address sequence with a release after every buffer, wrapping back to buffer 0.
        apply_reset(BASE, STRIDE);
        for (int i = 0; i < 5; i++) begin
            frame_start(BASE + (i % 4) * STRIDE);
            transfer_done(i % 4);
            check("full_after_done", bus.full_mask, 32'(1) << (i % 4));
            release_buf(i % 4);
            check("full_after_release", bus.full_mask, 0);
        end

        // Fill the ring without releases; the in-flight buffer counts as occupied.
        apply_reset(BASE, STRIDE);
        for (int i = 0; i < 3; i++) begin
            frame_start(BASE + i * STRIDE);
            transfer_done(i);
        end
        frame_start(BASE + 3 * STRIDE);
        check("inhibit_in_flight", bus.capture_inhibit, 1);
        release_buf(3);
        check("release_in_flight_ignored", bus.full_mask, 4'h7);
        transfer_done(3);
        check("ring_full_mask", bus.full_mask, 4'hF);
        check("ring_full_inhibit", bus.capture_inhibit, 1);
        frame_drop(16'd1);
        release_buf(2);
        check("mask_after_release2", bus.full_mask, 4'hB);
        check("inhibit_after_release", bus.capture_inhibit, 0);
        frame_start(BASE + 2 * STRIDE);
        transfer_done(2);
        check("mask_refilled", bus.full_mask, 4'hF);

        // Frames arriving during a transfer are dropped, including one coincident with dma_done.
        release_buf(1);
        frame_start(BASE + 1 * STRIDE);
        frame_drop(16'd2);
        idx_q.push_back(1);
        bus.frame_done = 1'b1;
        bus.dma_done   = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        bus.dma_done   = 1'b0;
        check("coincident_overrun", bus.overrun_count, 16'd3);
        check("coincident_no_start", bus.start_dma, 0);
        check("coincident_ready", bus.buffer_ready, 1);
        if (bus.buffer_ready) check("coincident_ready_index", bus.ready_index, idx_q.pop_front());
        tick();
        check("no_back_to_back", bus.start_dma, 0);

        // Release of another index and completion in the same cycle both take effect.
        release_buf(0);
        frame_start(BASE);
        idx_q.push_back(0);
        bus.dma_done      = 1'b1;
        bus.release_valid = 1'b1;
        bus.release_index = 2'd3;
        tick();
        bus.dma_done      = 1'b0;
        bus.release_valid = 1'b0;
        check("release_plus_done_mask", bus.full_mask, 4'h7);
        if (bus.buffer_ready) check("release_plus_done_index", bus.ready_index, idx_q.pop_front());
        tick();
        // Releasing the buffer that completes in the same cycle is ignored.
        frame_start(BASE + 3 * STRIDE);
        bus.dma_done      = 1'b1;
        bus.release_valid = 1'b1;
        bus.release_index = 2'd3;
        tick();
        bus.dma_done      = 1'b0;
        bus.release_valid = 1'b0;
        check("release_completing_ignored", bus.full_mask, 4'hF);
        tick();

        // Disable mid-transfer: the transfer drains, then nothing re-arms.
        apply_reset(BASE, STRIDE);
        frame_start(BASE);
        bus.enable = 1'b0;
        tick();
        check("drain_busy", bus.busy, 1);
        frame_drop(16'd1);
        transfer_done(0);
        check("drain_full_mask", bus.full_mask, 4'h1);
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        check("idle_frame_no_start", bus.start_dma, 0);
        check("idle_frame_no_overrun", bus.overrun_count, 16'd1);
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        check("idle_dma_done_ignored", bus.buffer_ready, 0);

        // Address arithmetic wraps modulo 2^32.
        apply_reset(32'hFFFF_F000, STRIDE);
        frame_start(32'hFFFF_F000);
        transfer_done(0);
        frame_start(32'h0000_0000);
        transfer_done(1);
        frame_start(32'h0000_1000);

        // Asynchronous reset mid-cycle while a transfer is in flight.
        #2 reset = 1'b0;
        #1;
        check("async_dma_address", bus.dma_address, 0);
        check("async_busy", bus.busy, 0);
        check("async_full_mask", bus.full_mask, 0);
        check("async_ready_index", bus.ready_index, 0);
        check("async_inhibit", bus.capture_inhibit, 0);
        #2 reset = 1'b1;
        bus.enable   = 1'b0;
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        check("post_reset_done_ignored", bus.buffer_ready, 0);
        check("post_reset_full_mask", bus.full_mask, 0);

        // Overrun counter saturation with the ring full and frame_done held.
        apply_reset(BASE, STRIDE);
        for (int i = 0; i < 4; i++) begin
            frame_start(BASE + i * STRIDE);
            transfer_done(i);
        end
        bus.frame_done = 1'b1;
        repeat (65534) tick();
        check("overrun_fffe", bus.overrun_count, 16'hFFFE);
        tick();
        check("overrun_ffff", bus.overrun_count, 16'hFFFF);
        repeat (5) tick();
        bus.frame_done = 1'b0;
        check("overrun_saturated", bus.overrun_count, 16'hFFFF);
        check("saturation_no_start", bus.start_dma, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scope_buffer_scheduler.md
Name: scope_buffer_scheduler

Overview:
- Sequences scope capture frames into a ring of N_BUFFERS host memory buffers.
- Sits between the tlast generator (frame boundary pulse) and the DMA manager (start/done).
- Picks the next free buffer round-robin and computes its address, issues one DMA start per frame, and reports filled buffers to the host.
- Drops frames and counts overruns when no buffer is free or a transfer is still in flight, and raises an inhibit flag for the capture path.

Parameters:
N_BUFFERS, 4, number of ring buffers (2..8)
ADDR_WIDTH, 32, width of buffer addresses and stride
IDX_WIDTH, $clog2(N_BUFFERS), buffer index width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
enable  in  1  scheduler enable (level)
buffer_base  in  ADDR_WIDTH  address of buffer 0
buffer_stride  in  ADDR_WIDTH  byte distance between consecutive buffers
frame_done  in  1  one-cycle pulse: a capture frame has completed (tlast)
dma_done  in  1  one-cycle pulse: in-flight DMA transfer finished
release_valid  in  1  host frees a buffer this cycle
release_index  in  IDX_WIDTH  buffer being freed
start_dma  out  1  one-cycle DMA start pulse
dma_address  out  ADDR_WIDTH  target address for the current transfer
buffer_ready  out  1  one-cycle pulse: a buffer has been filled
ready_index  out  IDX_WIDTH  index of the filled buffer, valid with buffer_ready
full_mask  out  N_BUFFERS  bit i = 1: buffer i is filled and not yet released
capture_inhibit  out  1  1 when no buffer is free
busy  out  1  1 while a transfer is in flight
overrun_count  out  16  count of dropped frames, saturating

Behaviour:
- Reset (reset=0, async) clears:
  - outputs: start_dma, dma_address, buffer_ready, ready_index, full_mask, busy, overrun_count all 0.
  - internals: state=IDLE, next_idx=0.
- capture_inhibit is combinational: 1 when &full_mask and the in-flight buffer is counted as occupied. Occupied = full OR in-flight.
- FSM states: IDLE, ARMED, IN_FLIGHT, DRAIN.
- IDLE: enable=1 -> ARMED next cycle. frame_done ignored and not counted.
- ARMED, frame_done=1:
  - Free buffer exists: select the first free index scanning next_idx, next_idx+1, ... modulo N_BUFFERS.
  - Register dma_address = buffer_base + idx*buffer_stride, truncated to ADDR_WIDTH, wrap modulo 2^ADDR_WIDTH. base and stride are sampled in this cycle.
  - Pulse start_dma at t+1, go IN_FLIGHT, busy=1 from t+1.
  - No free buffer: overrun_count++ and stay ARMED.
- ARMED, enable=0 -> IDLE.
- IN_FLIGHT:
  - frame_done -> overrun_count++, frame dropped.
  - dma_done at t -> at t+1: full_mask[idx]=1, buffer_ready=1, ready_index=idx, busy=0, next_idx=idx+1 mod N_BUFFERS.
  - After dma_done: enable=1 -> ARMED, else IDLE.
  - enable=0 while in flight -> DRAIN.
- DRAIN: same as IN_FLIGHT but never re-arms. dma_done -> IDLE with the same completion actions.
- Release:
  - release_valid with full_mask[release_index]=1 clears that bit at t+1.
  - Release of a non-full, in-flight or out-of-range index is ignored.
  - Release and completion in the same cycle on different indices: both applied. Release of an index completing in that same cycle is ignored, because the bit is not yet set.
  - A release in the same cycle as a frame_done does not make that buffer eligible; eligibility uses registered full_mask.
- frame_done and dma_done in the same cycle while IN_FLIGHT: counted as overrun. No back-to-back start.
- dma_done outside IN_FLIGHT/DRAIN: ignored.
- overrun_count saturates at 16'hFFFF.
- Latencies: frame_done -> start_dma 1 cycle; dma_done -> buffer_ready 1 cycle.

Test Plan:
- Address sequence: reset, enable=1, base=0x1000_0000, stride=0x1000, N=4. Four frame/done pairs, release after each -> dma_address 0x10000000, 0x10001000, 0x10002000, 0x10003000, then back to 0x10000000; each start_dma 1 cycle after frame_done.
- Ring full: 4 frames with no release -> full_mask=4'hF, capture_inhibit=1. Fifth frame_done -> no start_dma, overrun_count=1. Then release index 2 -> next frame writes 0x10002000.
- Frame during transfer: frame_done while busy=1 -> overrun_count increments, no start_dma. dma_done -> buffer_ready with the correct ready_index.
- Wrap and saturation:
  - base=0xFFFF_F000, stride=0x1000 -> buffer 1 address 0x00000000.
  - Force 65540 drops -> overrun_count holds at 0xFFFF.
- Disable mid-transfer: enable=0 while IN_FLIGHT -> DRAIN; dma_done still sets the full bit and pulses buffer_ready. A subsequent frame_done -> no start_dma, no overrun.
- Async reset during IN_FLIGHT: assert reset mid-clock -> all outputs 0 immediately. After release, a dma_done pulse is ignored.
